// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain bitstream loader.
package ccff_loader_pkg;

  localparam int unsigned CCFF_BYTE_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } ccff_ld_state_t;

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Byte-stream valid/ready handshake feeding the loader.
interface ccff_bitstream_loader_if;
  import ccff_loader_pkg::*;

  logic [CCFF_BYTE_W-1:0] s_data;
  logic                   s_valid;
  logic                   s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/ccff_tail_deserializer.sv
// Captures the chain tail on every fabric shift and packs it into readback bytes,
// MSB = first captured bit. A final partial byte is left-aligned and zero-padded.
module ccff_tail_deserializer
  import ccff_loader_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   cap_en_i,
  input  logic                   tail_i,
  input  logic                   flush_i,
  output logic [CCFF_BYTE_W-1:0] rb_data_o,
  output logic                   rb_valid_o
);

  logic [CCFF_BYTE_W-2:0] shreg_q, shreg_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [CCFF_BYTE_W-1:0] rb_data_q, rb_data_d;
  logic                   rb_valid_q, rb_valid_d;
  logic [CCFF_BYTE_W-1:0] captured;

  assign captured = {shreg_q, tail_i};

  // Next-state: shift in the tail bit, emit on byte boundary or final flush.
  always_comb begin
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cap_en_i) begin
      shreg_d = captured[CCFF_BYTE_W-2:0];
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        rb_valid_d = 1'b1;
        rb_data_d  = captured;
      end else if (flush_i) begin
        // cnt_q+1 bits are valid in the low end; move them to the top.
        rb_valid_d = 1'b1;
        rb_data_d  = captured << (3'd7 - cnt_q);
        cnt_d      = '0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q    <= '0;
      cnt_q      <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_data_o  = rb_data_q;
  assign rb_valid_o = rb_valid_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serializes configuration bytes MSB-first into the ccff chain head, gating the
// fabric shift enable, and returns the chain's old contents as readback bytes.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 1024,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                     prog_clk,
  input  logic                     pReset_n,
  input  logic                     start,
  ccff_bitstream_loader_if.slave   s,
  output logic                     ccff_head,
  output logic                     ccff_clk_en,
  input  logic                     ccff_tail,
  output logic [CCFF_BYTE_W-1:0]   rb_data,
  output logic                     rb_valid,
  output logic                     busy,
  output logic                     done
);

  ccff_ld_state_t         state_q, state_d;
  logic [CNT_W-1:0]       bits_left_q, bits_left_d, bits_after;
  logic [CCFF_BYTE_W-1:0] buf_q, buf_d;
  logic [3:0]             buf_cnt_q, buf_cnt_d;
  logic                   head_q, head_d;
  logic                   clk_en_q, clk_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   shift, accept, start_ok;

  assign shift      = (state_q == StLoad) && (buf_cnt_q != 4'd0);
  assign start_ok   = (state_q == StIdle) && start;
  assign bits_after = bits_left_q - CNT_W'(shift);

  // Ready when empty, or when the last buffered bit leaves now and more are still owed.
  assign s.s_ready = (state_q == StLoad) &&
                     ((buf_cnt_q == 4'd0) ||
                      ((buf_cnt_q == 4'd1) && (bits_left_q > CNT_W'(1))));
  assign accept    = s.s_valid && s.s_ready;

  // Next-state for FSM, bit counter, shift buffer and registered chain outputs.
  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    buf_d       = buf_q;
    buf_cnt_d   = buf_cnt_q;
    head_d      = head_q;
    clk_en_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StLoad;
          bits_left_d = CNT_W'(CHAIN_LEN);
          buf_cnt_d   = 4'd0;
          busy_d      = 1'b1;
        end
      end
      StLoad: begin
        if (shift) begin
          head_d      = buf_q[CCFF_BYTE_W-1];
          clk_en_d    = 1'b1;
          buf_d       = buf_q << 1;
          buf_cnt_d   = buf_cnt_q - 4'd1;
          bits_left_d = bits_after;
        end
        if (accept) begin
          buf_d = s.s_data;
          // Only the bits still owed are kept; the rest of a final byte is dropped.
          if (32'(bits_after) >= CCFF_BYTE_W) buf_cnt_d = 4'd8;
          else                                buf_cnt_d = 4'(bits_after);
        end
        if (bits_after == '0) state_d = StDone;
      end
      StDone: begin
        // Last shift is being consumed by the fabric this cycle.
        state_d = StIdle;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q     <= StIdle;
      bits_left_q <= '0;
      buf_q       <= '0;
      buf_cnt_q   <= '0;
      head_q      <= 1'b0;
      clk_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      buf_q       <= buf_d;
      buf_cnt_q   <= buf_cnt_d;
      head_q      <= head_d;
      clk_en_q    <= clk_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ccff_head   = head_q;
  assign ccff_clk_en = clk_en_q;
  assign busy        = busy_q;
  assign done        = done_q;

  ccff_tail_deserializer u_tail_deser (
    .clk_i      (prog_clk),
    .rst_ni     (pReset_n),
    .clear_i    (start_ok),
    .cap_en_i   (clk_en_q),
    .tail_i     (ccff_tail),
    .flush_i    (state_q == StDone),
    .rb_data_o  (rb_data),
    .rb_valid_o (rb_valid)
  );

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench: two loaders (16- and 12-bit chains) each driving a behavioural chain,
// checked against a bit/byte-level reference model.
module tb_ccff_bitstream_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel, start_drv, valid_drv, pl_req;
  logic [7:0]  data_drv;
  logic [15:0] pl_val;
  logic [15:0] chain0;
  logic [11:0] chain1;
  logic        head0, en0, rbv0, busy0, done0;
  logic        head1, en1, rbv1, busy1, done1;
  logic [7:0]  rbd0, rbd1;

  ccff_bitstream_loader_if sif0 ();
  ccff_bitstream_loader_if sif1 ();
  assign sif0.s_data  = data_drv;
  assign sif0.s_valid = valid_drv & ~sel;
  assign sif1.s_data  = data_drv;
  assign sif1.s_valid = valid_drv & sel;

  ccff_bitstream_loader #(.CHAIN_LEN(16)) u_dut16 (
    .prog_clk    (clk),
    .pReset_n    (rst_n),
    .start       (start_drv & ~sel),
    .s           (sif0),
    .ccff_head   (head0),
    .ccff_clk_en (en0),
    .ccff_tail   (chain0[15]),
    .rb_data     (rbd0),
    .rb_valid    (rbv0),
    .busy        (busy0),
    .done        (done0)
  );

  ccff_bitstream_loader #(.CHAIN_LEN(12)) u_dut12 (
    .prog_clk    (clk),
    .pReset_n    (rst_n),
    .start       (start_drv & sel),
    .s           (sif1),
    .ccff_head   (head1),
    .ccff_clk_en (en1),
    .ccff_tail   (chain1[11]),
    .rb_data     (rbd1),
    .rb_valid    (rbv1),
    .busy        (busy1),
    .done        (done1)
  );

  // Fabric chain models: advance only on edges that see the enable high.
  always @(posedge clk) begin
    if (pl_req && !sel) chain0 <= pl_val;
    else if (en0)       chain0 <= {chain0[14:0], head0};
  end
  always @(posedge clk) begin
    if (pl_req && sel) chain1 <= pl_val[11:0];
    else if (en1)      chain1 <= {chain1[10:0], head1};
  end

  logic        head_m, en_m, rbv_m, busy_m, done_m, ready_m;
  logic [7:0]  rbd_m;
  logic [15:0] chain_m;
  assign head_m  = sel ? head1 : head0;
  assign en_m    = sel ? en1 : en0;
  assign rbv_m   = sel ? rbv1 : rbv0;
  assign busy_m  = sel ? busy1 : busy0;
  assign done_m  = sel ? done1 : done0;
  assign ready_m = sel ? sif1.s_ready : sif0.s_ready;
  assign rbd_m   = sel ? rbd1 : rbd0;
  assign chain_m = sel ? {4'h0, chain1} : chain0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_en, n_done, low_mid, n_acc, cur_len, start_cyc, done_cyc;
  bit active = 1'b0;
  logic       exp_bits[$];
  logic [7:0] exp_rb[$];
  logic [7:0] got_rb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Compare process: every cycle of an active load.
  initial begin
    forever begin
      @(negedge clk);
      if (active) begin
        if (en_m) begin
          n_en++;
          if (exp_bits.size() == 0) chk("shift_count", 32'(n_en), 32'(cur_len));
          else                      chk("head_bit", 32'(head_m), 32'(exp_bits.pop_front()));
        end else if (n_en > 0 && n_en < cur_len) begin
          low_mid++;
        end
        if (rbv_m) begin
          got_rb.push_back(rbd_m);
          if (exp_rb.size() == 0) chk("rb_count", 32'(got_rb.size()), 32'((cur_len + 7) / 8));
          else                    chk("rb_data", 32'(rbd_m), 32'(exp_rb.pop_front()));
        end
        if (done_m) begin
          n_done++;
          done_cyc = cyc;
          chk("rb_with_done", 32'(rbv_m), 32'd1);
        end
        if (n_acc >= 2) chk("ready_low_after_last", 32'(ready_m), 32'd0);
        if (n_done == 0) chk("busy_in_load", 32'(busy_m), 32'd1);
      end
    end
  end

  task automatic do_load(input bit d, input logic [15:0] pre, input logic [7:0] b0,
                         input logic [7:0] b1, input int g0, input int g1, input bit mid_start);
    int L;
    int idx;
    int n;
    logic [15:0] stream;
    logic [7:0]  v;
    L = d ? 12 : 16;
    sel = d;
    cur_len = L;
    @(negedge clk);
    pl_val = pre;
    pl_req = 1'b1;
    @(negedge clk);
    pl_req = 1'b0;
    // Reference: first L bits of the byte stream go in; old contents come out MSB first.
    exp_bits.delete();
    exp_rb.delete();
    got_rb.delete();
    stream = {b0, b1};
    for (int i = 0; i < L; i++) exp_bits.push_back(stream[15-i]);
    for (int i = 0; i < (L + 7) / 8; i++) begin
      v = 8'h00;
      for (int j = 0; j < 8; j++) begin
        idx = L - 1 - (8 * i + j);
        if (idx >= 0) v[7-j] = pre[idx];
      end
      exp_rb.push_back(v);
    end
    n_en = 0; n_done = 0; low_mid = 0; n_acc = 0;
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    start_cyc = cyc;
    active = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!ready_m && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("ready_before_byte", 32'(ready_m), 32'd1);
      repeat (k == 0 ? g0 : g1) @(negedge clk);
      data_drv  = (k == 0) ? b0 : b1;
      valid_drv = 1'b1;
      @(posedge clk);
      n_acc++;
      @(negedge clk);
      valid_drv = 1'b0;
      if (k == 0 && mid_start) begin
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
      end
    end
    n = 0;
    while (n_done == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    active = 1'b0;
    chk("enables", 32'(n_en), 32'(L));
    chk("done_count", 32'(n_done), 32'd1);
    chk("done_cycle", 32'(done_cyc - start_cyc), 32'(L + 2 + g0 + g1));
    chk("stall_gap", 32'(low_mid), 32'(g1));
    chk("chain", 32'(chain_m), 32'(stream >> (16 - L)));
    chk("rb_total", 32'(got_rb.size()), 32'((L + 7) / 8));
    chk("busy_after", 32'(busy_m), 32'd0);
  endtask

  function automatic logic [15:0] rb_word();
    if (got_rb.size() == 2) return {got_rb[0], got_rb[1]};
    return 16'hdead;
  endfunction

  logic [15:0] rpre;
  logic [7:0]  r0, r1;
  int          rg0, rg1, k5, n;
  bit          rd, rms;

  initial begin
    rst_n = 1'b0; sel = 1'b0; start_drv = 1'b0; valid_drv = 1'b0;
    data_drv = 8'h00; pl_req = 1'b0; pl_val = 16'h0000;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(ready_m), 32'd0);
    chk("reset_head", 32'(head_m), 32'd0);
    chk("reset_en", 32'(en_m), 32'd0);
    chk("reset_rb_data", 32'(rbd_m), 32'd0);
    chk("reset_rb_valid", 32'(rbv_m), 32'd0);
    chk("reset_busy", 32'(busy_m), 32'd0);
    chk("reset_done", 32'(done_m), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back load into a cleared 16-bit chain.
    do_load(1'b0, 16'h0000, 8'hA5, 8'h3C, 0, 0, 1'b0);
    chk("t1_chain", 32'(chain0), 32'h0000A53C);
    chk("t1_rb", 32'(rb_word()), 32'h00000000);
    chk("t1_done_cycle", 32'(done_cyc - start_cyc), 32'd18);

    // Five-cycle input stall between the bytes.
    do_load(1'b0, 16'h0000, 8'hA5, 8'h3C, 0, 5, 1'b0);
    chk("t4_chain", 32'(chain0), 32'h0000A53C);
    chk("t4_gap", 32'(low_mid), 32'd5);
    chk("t4_done_cycle", 32'(done_cyc - start_cyc), 32'd23);

    // Start pulsed mid-load must be ignored.
    do_load(1'b0, 16'h0F0F, 8'h3C, 8'hA5, 0, 0, 1'b1);
    chk("t5_done_once", 32'(n_done), 32'd1);
    chk("t5_rb", 32'(rb_word()), 32'h00000F0F);

    // Reload over known contents.
    do_load(1'b0, 16'hBEEF, 8'h12, 8'h34, 0, 0, 1'b0);
    chk("t2_chain", 32'(chain0), 32'h00001234);
    chk("t2_rb", 32'(rb_word()), 32'h0000BEEF);

    // Asynchronous reset after five shifted bits.
    sel = 1'b0;
    @(negedge clk);
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    data_drv  = 8'hFF;
    valid_drv = 1'b1;
    @(negedge clk);
    valid_drv = 1'b0;
    k5 = 0; n = 0;
    while (k5 < 5 && n < 50) begin
      @(negedge clk);
      n++;
      if (en0) k5++;
    end
    chk("rst_pre_shifts", 32'(k5), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_head", 32'(head0), 32'd0);
    chk("rst_en", 32'(en0), 32'd0);
    chk("rst_rb_data", 32'(rbd0), 32'd0);
    chk("rst_rb_valid", 32'(rbv0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_ready", 32'(sif0.s_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_load(1'b0, 16'hC3C3, 8'h5A, 8'h96, 0, 0, 1'b0);
    chk("rst_restart_chain", 32'(chain0), 32'h00005A96);

    // 12-bit chain: final byte truncated to its top four bits.
    do_load(1'b1, 16'h0C5A, 8'hF0, 8'hAB, 0, 0, 1'b0);
    chk("t3_chain", 32'(chain1), 32'h00000F0A);
    chk("t3_enables", 32'(n_en), 32'd12);
    chk("t3_rb", 32'(rb_word()), 32'h0000C5A0);

    // Randomized loads on both chain lengths.
    for (int it = 0; it < 24; it++) begin
      rd   = 1'($urandom_range(0, 1));
      rpre = 16'($urandom);
      r0   = 8'($urandom);
      r1   = 8'($urandom);
      rg0  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
      rg1  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 6)) : 0;
      rms  = 1'($urandom_range(0, 1));
      do_load(rd, rpre, r0, r1, rg0, rg1, rms);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "bench timeout");
  end

endmodule
